max7219_spi_arbiter: RTL

- Shares one spi_max7219 serialiser between NUM_REQ independent requesters, e.g. the init/config sequencer, the frame-buffer row refresher and a runtime intensity/test-mode controller.
- Grants one request, latches its data word and issues the one-cycle data-valid strobe.
- Tracks the serialiser's busy handshake to completion, then acknowledges the requester and enforces an inter-frame gap.
- Sits between the request sources and spi_max7219 inside the MAX7219 display subsystem.

---
 rtl/max7219_types_pkg.sv | 27 ++
 rtl/max7219_spi_arbiter_select.sv | 49 ++++
 rtl/max7219_spi_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/max7219_types_pkg.sv
// Shared types and helpers for the MAX7219 display subsystem arbiter.
package max7219_types;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT_RISE,
        ARB_WAIT_FALL,
        ARB_GAP
    } arb_state_t;

    localparam int unsigned ARB_DEFAULT_GAP = 4;

    function automatic int unsigned arb_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Width of a counter that must hold max_val; never narrower than one bit.
    function automatic int unsigned arb_cnt_w(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

    function automatic int unsigned arb_ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/max7219_spi_arbiter_select.sv
// One-hot winner select; round-robin when MAX7219_ARB_ROUND_ROBIN_EN is
// defined, otherwise fixed priority with the lowest index winning.
module max7219_arb_select
    import max7219_types::*;
#(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]            req,
`ifdef MAX7219_ARB_ROUND_ROBIN_EN
    input  logic [arb_ptr_w(NUM_REQ)-1:0] ptr,
`endif
    output logic [NUM_REQ-1:0]            win_c
);

`ifdef MAX7219_ARB_ROUND_ROBIN_EN
    localparam int unsigned PTR_W = arb_ptr_w(NUM_REQ);

    logic             found;
    logic [PTR_W-1:0] idx;

    // First requester at or after the pointer, wrapping at NUM_REQ.
    always_comb begin
        win_c = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((32'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                win_c[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
`else
    logic found;

    always_comb begin
        win_c = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                win_c[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/max7219_spi_arbiter.sv
// Shares one spi_max7219 serialiser between NUM_REQ requesters: grant, issue,
// track busy, ack, then enforce an inter-frame gap. Option: MAX7219_ARB_ROUND_ROBIN_EN.
module max7219_spi_arbiter
    import max7219_types::*;
#(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned GAP_CLOCKS   = ARB_DEFAULT_GAP,
    parameter int unsigned BUSY_TIMEOUT = 15
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic [NUM_REQ-1:0]            i_Req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_Data,
    output logic [NUM_REQ-1:0]            o_Ack,
    output logic [NUM_REQ-1:0]            o_Grant,
    output logic                          o_Timeout,
    input  logic                          i_SPI_Busy,
    output logic                          o_SPI_Data_Ready,
    output logic [DATA_WIDTH-1:0]         o_SPI_Data,
    output logic                          o_Busy
);

    localparam int unsigned CNT_MAX = arb_max(GAP_CLOCKS, BUSY_TIMEOUT);
    localparam int unsigned CNT_W   = arb_cnt_w(CNT_MAX);

    arb_state_t              state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt, cnt_inc;
    logic [NUM_REQ-1:0]      win_c;
    logic [DATA_WIDTH-1:0]   win_data;
    logic [NUM_REQ-1:0]      grant_nxt, ack_nxt;
    logic [DATA_WIDTH-1:0]   data_nxt;
    logic                    ready_nxt, timeout_nxt;

`ifdef MAX7219_ARB_ROUND_ROBIN_EN
    localparam int unsigned PTR_W = arb_ptr_w(NUM_REQ);
    logic [PTR_W-1:0] ptr, ptr_nxt;

    max7219_arb_select #(.NUM_REQ(NUM_REQ)) u_select (
        .req   (i_Req),
        .ptr   (ptr),
        .win_c (win_c)
    );
`else
    max7219_arb_select #(.NUM_REQ(NUM_REQ)) u_select (
        .req   (i_Req),
        .win_c (win_c)
    );
`endif

    always_comb begin
        win_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (win_c[k]) win_data = i_Data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Saturating increment so a long stall can never wrap back under the limit.
    assign cnt_inc = (cnt == CNT_W'(CNT_MAX)) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        grant_nxt   = o_Grant;
        data_nxt    = o_SPI_Data;
        ready_nxt   = 1'b0;
        ack_nxt     = '0;
        timeout_nxt = 1'b0;
`ifdef MAX7219_ARB_ROUND_ROBIN_EN
        ptr_nxt     = ptr;
`endif
        case (state)
            ARB_IDLE: begin
                if ((|i_Req) && !i_SPI_Busy) begin
                    grant_nxt = win_c;
                    data_nxt  = win_data;
                    state_nxt = ARB_ISSUE;
`ifdef MAX7219_ARB_ROUND_ROBIN_EN
                    for (int unsigned k = 0; k < NUM_REQ; k++) begin
                        if (win_c[k]) ptr_nxt = (k + 1 == NUM_REQ) ? '0 : PTR_W'(k + 1);
                    end
`endif
                end
            end
            ARB_ISSUE: begin
                ready_nxt = 1'b1;
                cnt_nxt   = '0;
                state_nxt = ARB_WAIT_RISE;
            end
            ARB_WAIT_RISE: begin
                if (i_SPI_Busy) begin
                    state_nxt = ARB_WAIT_FALL;
                end else if (cnt_inc >= CNT_W'(BUSY_TIMEOUT)) begin
                    timeout_nxt = 1'b1;
                    ack_nxt     = o_Grant;
                    grant_nxt   = '0;
                    cnt_nxt     = CNT_W'(GAP_CLOCKS);
                    state_nxt   = ARB_GAP;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ARB_WAIT_FALL: begin
                if (!i_SPI_Busy) begin
                    ack_nxt   = o_Grant;
                    grant_nxt = '0;
                    cnt_nxt   = CNT_W'(GAP_CLOCKS);
                    state_nxt = ARB_GAP;
                end
            end
            ARB_GAP: begin
                if (cnt == '0) state_nxt = ARB_IDLE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state            <= ARB_IDLE;
            cnt              <= '0;
            o_Grant          <= '0;
            o_SPI_Data       <= '0;
            o_SPI_Data_Ready <= 1'b0;
            o_Ack            <= '0;
            o_Timeout        <= 1'b0;
            o_Busy           <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            o_Grant          <= grant_nxt;
            o_SPI_Data       <= data_nxt;
            o_SPI_Data_Ready <= ready_nxt;
            o_Ack            <= ack_nxt;
            o_Timeout        <= timeout_nxt;
            o_Busy           <= (state_nxt != ARB_IDLE);
        end
    end

`ifdef MAX7219_ARB_ROUND_ROBIN_EN
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) ptr <= '0;
        else       ptr <= ptr_nxt;
    end
`endif

endmodule
